// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a word-organised, big-endian data memory.
// Handles byte/halfword/word loads with extension and sub-word stores by read-modify-write.
module load_store_unit #(
   parameter int unsigned MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

   state_t      state_q, state_d;
   logic        store_q, store_d;
   logic [1:0]  size_q, size_d;
   logic        sext_q, sext_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;

   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic [31:0] mem_write_data_q, mem_write_data_d;
   logic        mem_write_q, mem_write_d;
   logic        mem_read_q, mem_read_d;

   logic        req_err;

   // Lane k of a big-endian word sits at bits [31-8k : 24-8k].
   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic sext);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      h = off[1] ? word[15:0] : word[31:16];
      case (size)
         2'b00:   r = sext ? {{24{b[7]}}, b} : {24'b0, b};
         2'b01:   r = sext ? {{16{h[15]}}, h} : {16'b0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] wdata,
                                               input logic [1:0] size, input logic [1:0] off);
      logic [31:0] r;
      r = word;
      if (size == 2'b00) begin
         case (off)
            2'd0:    r[31:24] = wdata[7:0];
            2'd1:    r[23:16] = wdata[7:0];
            2'd2:    r[15:8]  = wdata[7:0];
            default: r[7:0]   = wdata[7:0];
         endcase
      end else if (off[1]) begin
         r[15:0] = wdata;
      end else begin
         r[31:16] = wdata;
      end
      return r;
   endfunction

   always_comb begin
      req_err = (req_size == 2'b11)
             || (req_size == 2'b01 && req_addr[0])
             || (req_size == 2'b10 && (req_addr[1:0] != 2'b00))
             || ({1'b0, req_addr} >= MEM_BYTES);
   end

   // Strobes and response fields default to zero so they are only ever high in their own state.
   always_comb begin
      state_d          = state_q;
      store_d          = store_q;
      size_d           = size_q;
      sext_d           = sext_q;
      addr_d           = addr_q;
      wdata_d          = wdata_q;
      resp_valid_d     = 1'b0;
      resp_err_d       = 1'b0;
      resp_rdata_d     = 32'h0;
      mem_address_d    = 32'h0;
      mem_write_data_d = 32'h0;
      mem_write_d      = 1'b0;
      mem_read_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               store_d = req_store;
               size_d  = req_size;
               sext_d  = req_signed;
               addr_d  = req_addr;
               wdata_d = req_wdata[15:0];
               if (req_err) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_store && req_size == 2'b10) begin
                  state_d          = WRITE;
                  mem_write_d      = 1'b1;
                  mem_address_d    = {req_addr[31:2], 2'b00};
                  mem_write_data_d = req_wdata;
               end else begin
                  state_d       = READ;
                  mem_read_d    = 1'b1;
                  mem_address_d = {req_addr[31:2], 2'b00};
               end
            end
         end
         READ: begin
            if (store_q) begin
               state_d          = WRITE;
               mem_write_d      = 1'b1;
               mem_address_d    = {addr_q[31:2], 2'b00};
               mem_write_data_d = store_merge(mem_read_data, wdata_q, size_q, addr_q[1:0]);
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_extract(mem_read_data, size_q, addr_q[1:0], sext_q);
            end
         end
         WRITE: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Asynchronous reset drops any strobe immediately, so a pending write never reaches memory.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         store_q          <= 1'b0;
         size_q           <= 2'b00;
         sext_q           <= 1'b0;
         addr_q           <= 32'h0;
         wdata_q          <= 16'h0;
         resp_valid_q     <= 1'b0;
         resp_err_q       <= 1'b0;
         resp_rdata_q     <= 32'h0;
         mem_address_q    <= 32'h0;
         mem_write_data_q <= 32'h0;
         mem_write_q      <= 1'b0;
         mem_read_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         store_q          <= store_d;
         size_q           <= size_d;
         sext_q           <= sext_d;
         addr_q           <= addr_d;
         wdata_q          <= wdata_d;
         resp_valid_q     <= resp_valid_d;
         resp_err_q       <= resp_err_d;
         resp_rdata_q     <= resp_rdata_d;
         mem_address_q    <= mem_address_d;
         mem_write_data_q <= mem_write_data_d;
         mem_write_q      <= mem_write_d;
         mem_read_q       <= mem_read_d;
      end
   end

   assign req_ready      = (state_q == IDLE) && !reset;
   assign resp_valid     = resp_valid_q;
   assign resp_err       = resp_err_q;
   assign resp_rdata     = resp_rdata_q;
   assign mem_address    = mem_address_q;
   assign mem_write_data = mem_write_data_q;
   assign mem_write      = mem_write_q;
   assign mem_read       = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a negedge word memory plus a byte-array reference model
// that predicts load data, memory contents, latency and strobe counts.
module tb_load_store_unit;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_read_data;

   int nchecks = 0;
   int nerr = 0;
   logic both_strobes_seen = 1'b0;

   logic [31:0] mem [0:255];
   logic [7:0]  ref_bytes [0:1023];

   load_store_unit #(.MEM_WORDS(256)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory acts on the falling edge; read data is held until the next read.
   always @(negedge clk) begin
      if (mem_read && mem_write) both_strobes_seen <= 1'b1;
      if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
      if (mem_read) mem_read_data <= mem[mem_address[9:2]];
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic model_err(input logic [31:0] ad, input logic [1:0] sz);
      return (sz == 2'b11) || (ad >= 32'd1024) || (sz == 2'b01 && ad % 2 != 0)
          || (sz == 2'b10 && ad % 4 != 0);
   endfunction

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] ad, input logic [1:0] sz, input logic sx);
      logic [31:0] v;
      int n;
      n = nbytes(sz);
      v = 0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_bytes[ad + i]);
      if (sx && n == 1 && v[7]) v = v | 32'hFFFF_FF00;
      if (sx && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] ad);
      logic [31:0] base;
      base = ad & ~32'd3;
      return {ref_bytes[base], ref_bytes[base + 1], ref_bytes[base + 2], ref_bytes[base + 3]};
   endfunction

   task automatic model_store(input logic [31:0] ad, input logic [1:0] sz, input logic [31:0] wd);
      int n;
      n = nbytes(sz);
      for (int i = 0; i < n; i++) ref_bytes[ad + i] = 8'(wd >> (8 * (n - 1 - i)));
   endtask

   // One full transaction: drive, scramble inputs after acceptance, then watch strobes until the response.
   task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic sx,
                                input logic [31:0] ad, input logic [31:0] wd, output logic [31:0] rd);
      logic        exp_err, err;
      logic [31:0] exp_rd, exp_wword, wword;
      int          exp_lat, exp_reads, exp_writes, lat, reads, writes;
      logic        addr_bad;
      exp_err    = model_err(ad, sz);
      exp_rd     = (!st && !exp_err) ? model_load(ad, sz, sx) : 32'h0;
      exp_wword  = 32'h0;
      if (st && !exp_err) begin
         model_store(ad, sz, wd);
         exp_wword = model_word(ad);
      end
      exp_lat    = exp_err ? 1 : (st && sz != 2'b10) ? 3 : 2;
      exp_reads  = (exp_err || (st && sz == 2'b10)) ? 0 : 1;
      exp_writes = (st && !exp_err) ? 1 : 0;

      @(negedge clk);
      checkOutput("ready_before", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sx;
      req_addr = ad; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_store  = 1'($urandom_range(0, 1));
      req_size   = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom_range(0, 1));
      req_addr   = $urandom;
      req_wdata  = $urandom;

      lat = 0; reads = 0; writes = 0; wword = 0; rd = 0; err = 0; addr_bad = 0;
      for (int n = 1; n <= 6 && lat == 0; n++) begin
         @(negedge clk);
         if (mem_read || mem_write) begin
            if (mem_address !== {ad[31:2], 2'b00}) addr_bad = 1'b1;
         end
         if (mem_read) reads++;
         if (mem_write) begin
            writes++;
            wword = mem_write_data;
         end
         if (resp_valid) begin
            lat = n; rd = resp_rdata; err = resp_err;
         end
      end
      checkOutput("latency", 32'(lat), 32'(exp_lat));
      checkOutput("resp_err", 32'(err), 32'(exp_err));
      checkOutput("resp_rdata", rd, exp_rd);
      checkOutput("mem_reads", 32'(reads), 32'(exp_reads));
      checkOutput("mem_writes", 32'(writes), 32'(exp_writes));
      checkOutput("mem_addr_ok", 32'(addr_bad), 32'd0);
      if (exp_writes != 0) checkOutput("write_word", wword, exp_wword);
      @(negedge clk);
      checkOutput("resp_pulse", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] rd, r1, r2, old12, ad;
      logic [5:0]  resp_pat, rdy_pat;
      logic        st;
      logic [1:0]  sz;

      reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      for (int w = 0; w < 256; w++) begin
         mem[w] = $urandom;
         {ref_bytes[4*w], ref_bytes[4*w+1], ref_bytes[4*w+2], ref_bytes[4*w+3]} = mem[w];
      end

      repeat (2) @(negedge clk);
      checkOutput("rst_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
      checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
      checkOutput("rst_mem_address", mem_address, 32'd0);
      checkOutput("rst_mem_wdata", mem_write_data, 32'd0);
      checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
      checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
      reset = 1'b0;

      applyStimulus(1'b1, 2'b10, 1'b0, 32'd8, 32'h1234_5678, rd);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, rd);
      checkOutput("lw8_const", rd, 32'h1234_5678);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'd4, 32'h80FF_007F, rd);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'd4, 32'h0, rd);
      checkOutput("lb4_const", rd, 32'hFFFF_FF80);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'd7, 32'h0, rd);
      checkOutput("lbu7_const", rd, 32'h0000_007F);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'd4, 32'h0, rd);
      checkOutput("lh4_const", rd, 32'hFFFF_80FF);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'd6, 32'h0, rd);
      checkOutput("lhu6_const", rd, 32'h0000_007F);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'd5, 32'h0, rd);
      checkOutput("lb5_const", rd, 32'hFFFF_FFFF);

      applyStimulus(1'b1, 2'b00, 1'b0, 32'd10, 32'h0000_00AB, rd);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, rd);
      checkOutput("rmw_const", rd, 32'h1234_AB78);

      applyStimulus(1'b0, 2'b10, 1'b0, 32'd6, 32'h0, rd);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'd3, 32'hFFFF, rd);
      applyStimulus(1'b0, 2'b11, 1'b0, 32'd0, 32'h0, rd);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'd1024, 32'h0, rd);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'd1023, 32'h0, rd);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'd1022, 32'hBEEF, rd);

      // Reset lands inside the WRITE cycle, before the memory's falling edge.
      old12 = model_word(32'd12);
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'd12; req_wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checkOutput("rst_mid_write_pre", 32'(mem_write), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("rst_mid_write_drop", 32'(mem_write), 32'd0);
      checkOutput("rst_mid_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid_ready_after", 32'(req_ready), 32'd1);
      for (int n = 0; n < 3; n++) begin
         checkOutput("rst_mid_no_resp", 32'(resp_valid), 32'd0);
         @(negedge clk);
      end
      applyStimulus(1'b0, 2'b10, 1'b0, 32'd12, 32'h0, rd);
      checkOutput("rst_mid_mem_kept", rd, old12);

      // Two loads with req_valid held high: second waits for the first response.
      r1 = 0; r2 = 0; resp_pat = 0; rdy_pat = 0;
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'd8;
      @(posedge clk);
      #1;
      req_addr = 32'd4;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         resp_pat[n-1] = resp_valid;
         rdy_pat[n-1]  = req_ready;
         if (n == 2) r1 = resp_rdata;
         if (n == 5) r2 = resp_rdata;
         if (n == 3) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
         end
      end
      checkOutput("b2b_resp_pattern", 32'(resp_pat), 32'b010010);
      checkOutput("b2b_ready_pattern", 32'(rdy_pat), 32'b100100);
      checkOutput("b2b_first_data", r1, model_load(32'd8, 2'b10, 1'b0));
      checkOutput("b2b_second_data", r2, model_load(32'd4, 2'b10, 1'b0));
      checkOutput("b2b_first_const", r1, 32'h1234_AB78);
      checkOutput("b2b_second_const", r2, 32'h80FF_007F);

      for (int i = 0; i < 60; i++) begin
         st = 1'($urandom_range(0, 1));
         sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         case ($urandom_range(0, 9))
            0:       ad = 32'd1024 + $urandom_range(0, 4000);
            1:       ad = $urandom;
            default: ad = $urandom_range(0, 1023);
         endcase
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'b01) ad[0] = 1'b0;
            if (sz == 2'b10) ad[1:0] = 2'b00;
         end
         applyStimulus(st, sz, 1'($urandom_range(0, 1)), ad, $urandom, rd);
      end

      checkOutput("strobes_exclusive", 32'(both_strobes_seen), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nchecks, nerr);
      $finish;
   end

endmodule
